des3_cbc_seq: RTL and testbench

Block-mode sequencer that sits directly upstream of the DES3 core. It feeds the core's data input and start pulse, and consumes its output and valid flag. 64-bit blocks stream in through a ready/valid port and are buffered in an input FIFO. The block applies ECB or CBC chaining for encrypt or decrypt, runs one block at a time through the core, and returns results through an output FIFO. This lets software or a DMA push multi-block messages instead of hand-driving start per block.

---
 rtl/des3_cbc_seq.sv | 186 ++++++++++++++++++
 tb/tb_des3_cbc_seq.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/des3_cbc_seq.sv
// Block-mode sequencer in front of a DES3 core: buffers 64-bit blocks, applies
// ECB or CBC chaining in either direction, and runs one block at a time through the core.
module des3_cbc_seq #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        cfg_cbc,
   input  logic        cfg_decrypt,
   input  logic        iv_load,
   input  logic [63:0] iv_i,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [63:0] in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_data,
   output logic        core_start,
   output logic        core_decrypt,
   output logic [63:0] core_din,
   input  logic [63:0] core_dout,
   input  logic        core_valid,
   output logic        busy,
   output logic [31:0] blk_cnt,
   output logic [1:0]  dbg_state_o,
   output logic [63:0] dbg_chain_o
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [AW:0] PTR_INC = {{AW{1'b0}}, 1'b1};

   // Handshake rule: a transfer happens on a rising edge where valid and ready are both high.
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_WAIT  = 2'd2,
      S_PUSH  = 2'd3
   } state_t;

   state_t      state_q;
   logic [63:0] chain_q;
   logic [63:0] hold_q;
   logic [63:0] res_q;
   logic        mode_cbc_q;
   logic        core_dec_q;
   logic [63:0] core_din_q;
   logic        core_start_q;
   logic [31:0] blk_cnt_q;

   logic [63:0] ifq_mem_q [FIFO_DEPTH];
   logic [AW:0] ifq_wr_q;
   logic [AW:0] ifq_rd_q;
   logic        ifq_empty;
   logic        ifq_full;
   logic        ifq_push;
   logic        ifq_pop;
   logic [63:0] ifq_head;

   logic [63:0] ofq_mem_q [FIFO_DEPTH];
   logic [AW:0] ofq_wr_q;
   logic [AW:0] ofq_rd_q;
   logic        ofq_empty;
   logic        ofq_full;
   logic        ofq_push;
   logic        ofq_pop;
   logic [63:0] ofq_wdata;

   logic [63:0] res_d;

   // Input FIFO
   assign ifq_empty = (ifq_wr_q == ifq_rd_q);
   assign ifq_full  = (ifq_wr_q[AW] != ifq_rd_q[AW]) &&
                      (ifq_wr_q[AW-1:0] == ifq_rd_q[AW-1:0]);
   assign ifq_head  = ifq_mem_q[ifq_rd_q[AW-1:0]];
   assign in_ready  = !ifq_full;
   assign ifq_push  = in_valid && !ifq_full;
   assign ifq_pop   = (state_q == S_IDLE) && !iv_load && !ifq_empty;

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         ifq_wr_q <= '0;
         ifq_rd_q <= '0;
      end else begin
         if (ifq_push) begin
            ifq_mem_q[ifq_wr_q[AW-1:0]] <= in_data;
            ifq_wr_q <= ifq_wr_q + PTR_INC;
         end
         if (ifq_pop) begin
            ifq_rd_q <= ifq_rd_q + PTR_INC;
         end
      end
   end

   // Output FIFO; a write only happens when there is room, so a pop on a full FIFO
   // frees a slot for the next cycle rather than this one.
   assign ofq_empty = (ofq_wr_q == ofq_rd_q);
   assign ofq_full  = (ofq_wr_q[AW] != ofq_rd_q[AW]) &&
                      (ofq_wr_q[AW-1:0] == ofq_rd_q[AW-1:0]);
   assign out_valid = !ofq_empty;
   assign out_data  = ofq_mem_q[ofq_rd_q[AW-1:0]];
   assign ofq_pop   = !ofq_empty && out_ready;
   assign ofq_push  = (((state_q == S_WAIT) && core_valid) || (state_q == S_PUSH)) && !ofq_full;
   assign ofq_wdata = (state_q == S_PUSH) ? res_q : res_d;

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         ofq_wr_q <= '0;
         ofq_rd_q <= '0;
      end else begin
         if (ofq_push) begin
            ofq_mem_q[ofq_wr_q[AW-1:0]] <= ofq_wdata;
            ofq_wr_q <= ofq_wr_q + PTR_INC;
         end
         if (ofq_pop) begin
            ofq_rd_q <= ofq_rd_q + PTR_INC;
         end
      end
   end

   // CBC decrypt undoes the chaining after the core; every other mode passes the core output.
   assign res_d = (mode_cbc_q && core_dec_q) ? (core_dout ^ chain_q) : core_dout;

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q      <= S_IDLE;
         chain_q      <= '0;
         hold_q       <= '0;
         res_q        <= '0;
         mode_cbc_q   <= 1'b0;
         core_dec_q   <= 1'b0;
         core_din_q   <= '0;
         core_start_q <= 1'b0;
         blk_cnt_q    <= '0;
      end else begin
         core_start_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (iv_load) begin
                  chain_q   <= iv_i;
                  blk_cnt_q <= '0;
               end else if (!ifq_empty) begin
                  mode_cbc_q   <= cfg_cbc;
                  core_dec_q   <= cfg_decrypt;
                  hold_q       <= ifq_head;
                  core_din_q   <= (cfg_cbc && !cfg_decrypt) ? (ifq_head ^ chain_q) : ifq_head;
                  core_start_q <= 1'b1;
                  state_q      <= S_START;
               end
            end
            S_START: begin
               state_q <= S_WAIT;
            end
            S_WAIT: begin
               if (core_valid) begin
                  if (mode_cbc_q) begin
                     chain_q <= core_dec_q ? hold_q : core_dout;
                  end
                  res_q <= res_d;
                  if (!ofq_full) begin
                     blk_cnt_q <= blk_cnt_q + 32'd1;
                     state_q   <= S_IDLE;
                  end else begin
                     state_q <= S_PUSH;
                  end
               end
            end
            S_PUSH: begin
               if (!ofq_full) begin
                  blk_cnt_q <= blk_cnt_q + 32'd1;
                  state_q   <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign core_start   = core_start_q;
   assign core_decrypt = core_dec_q;
   assign core_din     = core_din_q;
   assign busy         = (state_q != S_IDLE);
   assign blk_cnt      = blk_cnt_q;
   assign dbg_state_o  = state_q;
   assign dbg_chain_o  = chain_q;

endmodule

// File: tb/tb_des3_cbc_seq.sv
// Directed bench for des3_cbc_seq with a stand-in core: a fixed-latency invertible
// mixer that also maps the classic DES test pair 0123456789ABCDEF <-> 85E813540F0AB405.
module tb_des3_cbc_seq;

   localparam int          L    = 4;
   localparam logic [63:0] P    = 64'h0123456789ABCDEF;
   localparam logic [63:0] C    = 64'h85E813540F0AB405;
   localparam logic [63:0] PXC  = 64'h84CB563386A179EA;
   localparam logic [63:0] C2   = 64'h6EF33C899D457C12;
   localparam logic [63:0] MK   = 64'hA5A50F0F3C3C9696;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cfg_cbc = 1'b0;
   logic        cfg_decrypt = 1'b0;
   logic        iv_load = 1'b0;
   logic [63:0] iv_i = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [63:0] in_data = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [63:0] out_data;
   logic        core_start;
   logic        core_decrypt;
   logic [63:0] core_din;
   logic [63:0] core_dout;
   logic        core_valid;
   logic        busy;
   logic [31:0] blk_cnt;
   logic [1:0]  dbg_state;
   logic [63:0] dbg_chain;

   int checks = 0;
   int failures = 0;
   logic [63:0] exp_q[$];

   des3_cbc_seq #(.FIFO_DEPTH(4)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst), .cfg_cbc(cfg_cbc), .cfg_decrypt(cfg_decrypt),
      .iv_load(iv_load), .iv_i(iv_i), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .core_start(core_start), .core_decrypt(core_decrypt), .core_din(core_din),
      .core_dout(core_dout), .core_valid(core_valid), .busy(busy), .blk_cnt(blk_cnt),
      .dbg_state_o(dbg_state), .dbg_chain_o(dbg_chain)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] enc(input logic [63:0] x);
      if (x == P) return C;
      return {x[55:0], x[63:56]} ^ MK;
   endfunction

   function automatic logic [63:0] dec(input logic [63:0] y);
      logic [63:0] t;
      if (y == C) return P;
      t = y ^ MK;
      return {t[7:0], t[63:8]};
   endfunction

   // Stand-in core: not reset by the sequencer, so a block cut off by reset still answers late.
   logic        cv_q = 1'b0;
   logic [63:0] cd_q = '0;
   logic        stray = 1'b0;
   logic        pend = 1'b0;
   int          lat_cnt = 0;
   logic [63:0] din_lat = '0;
   logic        dec_lat = 1'b0;
   int          start_cnt = 0;

   always @(posedge clk) begin
      cv_q <= 1'b0;
      if (core_start) start_cnt <= start_cnt + 1;
      if (core_start && !pend) begin
         pend    <= 1'b1;
         lat_cnt <= L;
         din_lat <= core_din;
         dec_lat <= core_decrypt;
      end else if (pend) begin
         if (lat_cnt == 1) begin
            pend <= 1'b0;
            cv_q <= 1'b1;
            cd_q <= dec_lat ? dec(din_lat) : enc(din_lat);
         end else begin
            lat_cnt <= lat_cnt - 1;
         end
      end
   end

   assign core_valid = cv_q | stray;
   assign core_dout  = cd_q;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic push_blk(input logic [63:0] d);
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         if (in_ready) begin
            in_valid = 1'b1;
            in_data  = d;
            @(negedge clk);
            in_valid = 1'b0;
            return;
         end
      end
      check("push_timeout", 64'(in_ready), 64'd1);
   endtask

   task automatic expect_out(input string tag, input logic [63:0] exp);
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         if (out_valid) begin
            check(tag, out_data, exp);
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            return;
         end
      end
      check({tag, "_timeout"}, 64'(out_valid), 64'd1);
   endtask

   task automatic wait_idle();
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         if (!busy) return;
      end
      check("idle_timeout", 64'(busy), 64'd0);
   endtask

   task automatic wait_state(input logic [1:0] s);
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         if (dbg_state == s) return;
      end
      check("state_timeout", 64'(dbg_state), 64'(s));
   endtask

   task automatic set_mode(input logic cbc, input logic decr, input logic [63:0] iv);
      wait_idle();
      cfg_cbc     = cbc;
      cfg_decrypt = decr;
      iv_i        = iv;
      iv_load     = 1'b1;
      @(negedge clk);
      iv_load = 1'b0;
   endtask

   initial begin
      int s0;
      logic [63:0] b1, b2, o1, d;

      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_blk_cnt", 64'(blk_cnt), 64'd0);
      check("rst_core_start", 64'(core_start), 64'd0);
      check("rst_core_din", core_din, 64'd0);
      check("rst_core_decrypt", 64'(core_decrypt), 64'd0);
      check("rst_chain", dbg_chain, 64'd0);

      // ECB encrypt of the classic vector
      s0 = start_cnt;
      push_blk(P);
      expect_out("ecb_out", C);
      check("ecb_blk_cnt", 64'(blk_cnt), 64'd1);
      check("ecb_start_pulses", 64'(start_cnt - s0), 64'd1);
      check("ecb_core_din", din_lat, P);
      check("ecb_chain_untouched", dbg_chain, 64'd0);

      // CBC encrypt, IV = 0
      set_mode(1'b1, 1'b0, 64'd0);
      push_blk(P);
      push_blk(P);
      expect_out("cbc_enc_out1", C);
      expect_out("cbc_enc_out2", C2);
      check("cbc_enc_core_din2", din_lat, PXC);
      check("cbc_enc_chain", dbg_chain, C2);
      check("cbc_enc_blk_cnt", 64'(blk_cnt), 64'd2);

      // CBC decrypt of the two ciphertexts
      set_mode(1'b1, 1'b1, 64'd0);
      push_blk(C);
      push_blk(C2);
      expect_out("cbc_dec_out1", P);
      expect_out("cbc_dec_out2", P);
      check("cbc_dec_chain", dbg_chain, C2);
      check("cbc_dec_core_decrypt", 64'(core_decrypt), 64'd1);

      // Backpressure: 4 in output FIFO, 1 parked in PUSH, 4 filling the input FIFO
      set_mode(1'b0, 1'b0, 64'd0);
      for (int i = 0; i < 9; i++) begin
         d = 64'h0F1E2D3C4B5A6978 + 64'(i) * 64'h0001000100010001;
         exp_q.push_back(enc(d));
         push_blk(d);
      end
      repeat (40) @(negedge clk);
      check("bp_state_push", 64'(dbg_state), 64'd3);
      check("bp_in_ready_low", 64'(in_ready), 64'd0);
      check("bp_blk_cnt_held", 64'(blk_cnt), 64'd4);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      for (int i = 0; i < 9; i++) begin
         expect_out("bp_drain", exp_q.pop_front());
      end
      repeat (3) @(negedge clk);
      check("bp_empty_after", 64'(out_valid), 64'd0);
      check("bp_blk_cnt_final", 64'(blk_cnt), 64'd9);

      // iv_load while busy is ignored
      b1 = 64'hCAFEBABEDEADBEEF;
      b2 = 64'h0011223344556677;
      set_mode(1'b1, 1'b0, 64'h1122334455667788);
      push_blk(b1);
      wait_state(2'd1);
      iv_i    = 64'hFFFFFFFFFFFFFFFF;
      iv_load = 1'b1;
      repeat (2) @(negedge clk);
      iv_load = 1'b0;
      o1 = enc(b1 ^ 64'h1122334455667788);
      expect_out("ivbusy_out1", o1);
      check("ivbusy_chain", dbg_chain, o1);
      check("ivbusy_blk_cnt", 64'(blk_cnt), 64'd1);
      push_blk(b2);
      expect_out("ivbusy_out2", enc(b2 ^ o1));
      check("ivbusy_core_din2", din_lat, b2 ^ o1);

      // Stray core_valid while idle
      wait_idle();
      stray = 1'b1;
      @(negedge clk);
      stray = 1'b0;
      repeat (5) @(negedge clk);
      check("stray_out_valid", 64'(out_valid), 64'd0);
      check("stray_blk_cnt", 64'(blk_cnt), 64'd2);
      check("stray_state", 64'(dbg_state), 64'd0);

      // Reset while waiting on the core
      push_blk(64'h5555AAAA5555AAAA);
      wait_state(2'd2);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rstwait_busy", 64'(busy), 64'd0);
      check("rstwait_out_valid", 64'(out_valid), 64'd0);
      check("rstwait_blk_cnt", 64'(blk_cnt), 64'd0);
      check("rstwait_chain", dbg_chain, 64'd0);
      repeat (12) @(negedge clk);
      check("rstwait_late_out_valid", 64'(out_valid), 64'd0);
      check("rstwait_late_state", 64'(dbg_state), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
